// File: rtl/irq_vector_ctrl_pkg.sv
// Shared definitions for the interrupt vector controller: FSM encoding,
// configuration register offsets and the vector address helper.
package irq_vector_ctrl_pkg;

  localparam int ID_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_VBASE   = 2'd3;

  // Each channel owns one 32-bit slot in the vector table.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [ID_W-1:0] id);
    return base + {25'd0, id, 2'b00};
  endfunction

endpackage

// File: rtl/irq_vector_ctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc
  import irq_vector_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt vector controller: edge/level pending capture, enable masking,
// single-level request/acknowledge/return handshake with the core.
module irq_vector_ctrl
  import irq_vector_ctrl_pkg::*;
#(
  parameter int             NCH       = 32,
  parameter logic [NCH-1:0] EDGE_MASK = '1,
  parameter logic [31:0]    VEC_BASE  = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] inirr,
  input  logic [31:0]    pc,
  input  logic           irq_ack,
  input  logic           irq_iret,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_addr,
  input  logic [31:0]    cfg_wdata,
  output logic [31:0]    cfg_rdata,
  output logic           irq_req,
  output logic [31:0]    irq_dest,
  output logic [31:0]    irq_ret,
  output logic [4:0]     irq_id,
  output logic [NCH-1:0] outirr
);

  irq_state_e      state_q, state_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;
  logic [31:0]     irq_ret_q, irq_ret_d;
  logic [31:0]     vbase_q, vbase_d;
  logic [NCH-1:0]  outirr_q, outirr_d;
  logic [NCH-1:0]  enable_q, enable_d;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  inirr_q;
  logic [NCH-1:0]  active, id_onehot, ack_clr, clr_mask;
  logic            pend_wr;
  logic [ID_W-1:0] enc_idx;
  logic            enc_valid;

  assign active    = pending_q & enable_q;
  assign id_onehot = {{(NCH-1){1'b0}}, 1'b1} << irq_id_q;
  assign pend_wr   = cfg_we && (cfg_addr == ADDR_PENDING);
  assign clr_mask  = (pend_wr ? cfg_wdata[NCH-1:0] : '0) | ack_clr;

  irq_prio_enc #(.N(NCH)) u_prio_enc (
    .req_i   (active),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // Edge channels latch a rise until cleared (a new rise beats a clear);
  // level channels simply track the sampled line.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_pend
    if (EDGE_MASK[gi]) begin : g_edge
      assign pending_d[gi] = (inirr[gi] & ~inirr_q[gi]) | (pending_q[gi] & ~clr_mask[gi]);
    end else begin : g_level
      assign pending_d[gi] = inirr[gi];
    end
  end

  always_comb begin
    enable_d = enable_q;
    vbase_d  = vbase_q;
    if (cfg_we && (cfg_addr == ADDR_ENABLE)) enable_d = cfg_wdata[NCH-1:0];
    if (cfg_we && (cfg_addr == ADDR_VBASE))  vbase_d  = {cfg_wdata[31:2], 2'b00};
  end

  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    irq_ret_d = irq_ret_q;
    outirr_d  = outirr_q;
    ack_clr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          irq_id_d = enc_idx;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // Acknowledge takes priority over a withdrawn request.
        if (irq_ack) begin
          irq_ret_d = pc;
          ack_clr   = id_onehot;
          outirr_d  = id_onehot;
          state_d   = ST_SERVICE;
        end else if ((active & id_onehot) == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (irq_iret) begin
          outirr_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        outirr_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      irq_ret_q <= '0;
      vbase_q   <= VEC_BASE;
      outirr_q  <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      inirr_q   <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      irq_ret_q <= irq_ret_d;
      vbase_q   <= vbase_d;
      outirr_q  <= outirr_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      inirr_q   <= inirr;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata[NCH-1:0] = enable_q;
      ADDR_PENDING: cfg_rdata[NCH-1:0] = pending_q;
      ADDR_STATUS: begin
        cfg_rdata[1:0] = state_q;
        cfg_rdata[8:4] = irq_id_q;
      end
      default:      cfg_rdata = vbase_q;
    endcase
  end

  assign irq_req  = (state_q == ST_REQ);
  assign irq_dest = vec_addr(vbase_q, irq_id_q);
  assign irq_ret  = irq_ret_q;
  assign irq_id   = irq_id_q;
  assign outirr   = outirr_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the controller.
module tb_irq_vector_ctrl;

  localparam logic [31:0] EMASK_P = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inirr;
  logic [31:0] pc;
  logic        irq_ack;
  logic        irq_iret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_req;
  logic [31:0] irq_dest;
  logic [31:0] irq_ret;
  logic [4:0]  irq_id;
  logic [31:0] outirr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_vector_ctrl #(
    .NCH       (32),
    .EDGE_MASK (EMASK_P),
    .VEC_BASE  (32'h0000_0100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inirr     (inirr),
    .pc        (pc),
    .irq_ack   (irq_ack),
    .irq_iret  (irq_iret),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_req   (irq_req),
    .irq_dest  (irq_dest),
    .irq_ret   (irq_ret),
    .irq_id    (irq_id),
    .outirr    (outirr)
  );

  // Behavioural model: 0 idle, 1 requesting, 2 in service.
  logic [31:0] emask = EMASK_P;
  logic [31:0] m_pend, m_prev, m_en, m_vbase, m_ret, m_out;
  int          m_state, m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_en;
      2'd1:    return m_pend;
      2'd2:    return 32'((m_id << 4) | m_state);
      default: return m_vbase;
    endcase
  endfunction

  task automatic m_step();
    logic [31:0] clr, nxt;
    if (rst) begin
      m_pend = 0; m_prev = 0; m_en = 0; m_vbase = 32'h100;
      m_ret = 0; m_out = 0; m_state = 0; m_id = 0;
      return;
    end
    clr = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 32'd0;
    case (m_state)
      0: begin
        for (int i = 0; i < 32; i++) begin
          if (m_pend[i] && m_en[i]) begin
            m_id = i;
            m_state = 1;
            break;
          end
        end
      end
      1: begin
        if (irq_ack) begin
          m_ret = pc;
          clr[m_id] = 1'b1;
          m_out = 32'd1 << m_id;
          m_state = 2;
        end else if (!(m_pend[m_id] && m_en[m_id])) begin
          m_state = 0;
        end
      end
      default: begin
        if (irq_iret) begin
          m_out = 0;
          m_state = 0;
        end
      end
    endcase
    for (int i = 0; i < 32; i++) begin
      if (emask[i]) nxt[i] = (inirr[i] && !m_prev[i]) || (m_pend[i] && !clr[i]);
      else          nxt[i] = inirr[i];
    end
    m_pend = nxt;
    m_prev = inirr;
    if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata;
    if (cfg_we && cfg_addr == 2'd3) m_vbase = cfg_wdata & 32'hFFFF_FFFC;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    #1;
    chk("req",   32'(irq_req), 32'(m_state == 1));
    chk("id",    32'(irq_id), 32'(m_id));
    chk("dest",  irq_dest, m_vbase + 32'(m_id * 4));
    chk("ret",   irq_ret, m_ret);
    chk("out",   outirr, m_out);
    chk("rdata", cfg_rdata, m_read(cfg_addr));
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] m);
    inirr = m;
    tick();
    inirr = 0;
  endtask

  task automatic peek(input logic [1:0] a);
    cfg_addr = a;
    #1;
  endtask

  initial begin
    rst = 1; inirr = 0; pc = 0; irq_ack = 0; irq_iret = 0;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    @(posedge clk);
    m_step();
    #1;
    tick();
    rst = 0;
    peek(2'd3); chk("reset_vbase", cfg_rdata, 32'h100);
    chk("reset_req", 32'(irq_req), 32'd0);

    $display("scenario: single edge channel 2, enable 0x5");
    cfg_write(2'd0, 32'h5);
    pulse(32'h4);
    tick();
    chk("lat_req", 32'(irq_req), 32'd1);
    chk("lat_id", 32'(irq_id), 32'd2);
    chk("lat_dest", irq_dest, 32'h108);
    irq_ack = 1; pc = 32'h1234; tick(); irq_ack = 0;
    irq_iret = 1; tick(); irq_iret = 0;
    chk("iret_out", outirr, 32'd0);

    $display("scenario: channels 1 and 3 together, enable 0xA");
    cfg_write(2'd0, 32'hA);
    pulse(32'hA);
    tick();
    chk("prio_id", 32'(irq_id), 32'd1);
    irq_ack = 1; pc = 32'h2000; tick(); irq_ack = 0;
    chk("ack_ret", irq_ret, 32'h2000);
    chk("ack_out", outirr, 32'h2);
    peek(2'd1); chk("ack_pend", cfg_rdata, 32'h8);
    irq_iret = 1; tick(); irq_iret = 0;
    chk("iret_out2", outirr, 32'd0);
    peek(2'd2); chk("iret_idle", cfg_rdata & 32'h3, 32'd0);
    tick();
    chk("second_req", 32'(irq_req), 32'd1);
    chk("second_id", 32'(irq_id), 32'd3);
    irq_ack = 1; tick(); irq_ack = 0;
    irq_iret = 1; tick(); irq_iret = 0;

    $display("scenario: withdraw channel 4 by pending clear");
    cfg_write(2'd0, 32'h10);
    pulse(32'h10);
    tick();
    chk("wd_id", 32'(irq_id), 32'd4);
    cfg_write(2'd1, 32'h10);
    tick();
    chk("wd_req", 32'(irq_req), 32'd0);
    peek(2'd2); chk("wd_state", cfg_rdata & 32'h3, 32'd0);

    $display("scenario: level channel 0 held through iret");
    cfg_write(2'd0, 32'h1);
    inirr = 32'h1;
    tick();
    tick();
    chk("lvl_req", 32'(irq_req), 32'd1);
    irq_ack = 1; tick(); irq_ack = 0;
    irq_iret = 1; tick(); irq_iret = 0;
    tick();
    chk("lvl_rereq", 32'(irq_req), 32'd1);
    chk("lvl_id", 32'(irq_id), 32'd0);
    cfg_write(2'd1, 32'h1);
    peek(2'd1); chk("lvl_w1c", cfg_rdata, 32'h1);
    chk("lvl_req2", 32'(irq_req), 32'd1);

    $display("scenario: reset during service");
    irq_ack = 1; pc = 32'h5555; tick(); irq_ack = 0;
    cfg_write(2'd3, 32'h3007);
    peek(2'd3); chk("vbase_wr", cfg_rdata, 32'h3004);
    chk("svc_dest", irq_dest, 32'h3004);
    chk("svc_out", outirr, 32'h1);
    rst = 1; tick(); rst = 0; inirr = 0;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_dest", irq_dest, 32'h100);
    chk("rst_ret", irq_ret, 32'd0);
    chk("rst_out", outirr, 32'd0);
    peek(2'd3); chk("rst_vbase", cfg_rdata, 32'h100);
    peek(2'd0); chk("rst_en", cfg_rdata, 32'd0);

    $display("scenario: randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      inirr     = $urandom & $urandom & $urandom;
      pc        = $urandom;
      irq_ack   = ($urandom_range(0, 3) == 0);
      irq_iret  = ($urandom_range(0, 3) == 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      tick();
    end
    rst = 0; cfg_we = 0; irq_ack = 0; irq_iret = 0; inirr = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_vector_ctrl.md
IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 Parameter NCH, default 32, meaning number of interrupt channels (2..32).
REQ-002 Parameter EDGE_MASK, default all-ones [NCH-1:0], meaning per channel 1=rising-edge, 0=level.
REQ-003 Parameter VEC_BASE, default 32'h0000_0100, meaning reset value of the vector base register.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 inirr  in  NCH  external interrupt lines, synchronous to clk.
REQ-008 pc  in  32  core PC to be saved on acknowledge.
REQ-009 irq_ack  in  1  core accepts the current request.
REQ-010 irq_iret  in  1  core signals return from service.
REQ-011 cfg_we  in  1  configuration write strobe.
REQ-012 cfg_addr  in  2  register select: 0 ENABLE, 1 PENDING, 2 STATUS, 3 VBASE.
REQ-013 cfg_wdata  in  32  write data.
REQ-014 cfg_rdata  out  32  read data, combinational from cfg_addr.
REQ-015 irq_req  out  1  interrupt request to core FSM.
REQ-016 irq_dest  out  32  vector address of the requested/in-service channel.
REQ-017 irq_ret  out  32  PC saved at acknowledge.
REQ-018 irq_id  out  5  index of requested/in-service channel.
REQ-019 outirr  out  NCH  one-hot in-service channel, zero when none.

Function
REQ-020 Edge channel: pending bit set the cycle after inirr rises (prev sample 0, current 1); held until cleared.
REQ-021 Level channel: pending bit equals registered inirr each cycle; W1C has no effect.
REQ-022 Write PENDING: each 1 in cfg_wdata clears that edge bit; simultaneous set and clear on same bit: set wins.
REQ-023 ENABLE read/write, bits above NCH read 0; VBASE read/write, bits [1:0] forced 0.
REQ-024 STATUS read: [1:0] state, [8:4] irq_id, [31:16] zero.
REQ-025 States IDLE(0), REQ(1), SERVICE(2); encoding 3 unreachable and recovers to IDLE.
REQ-026 IDLE: if (pending & enable) != 0, latch irq_id = lowest set index, go to REQ next cycle.
REQ-027 REQ: irq_req=1; irq_dest = VBASE + (irq_id << 2).
REQ-028 REQ and pending/enable bit of irq_id now 0 (cleared/disabled): return to IDLE next cycle, irq_req drops.
REQ-029 REQ with irq_ack: irq_ret <= pc, clear edge pending bit of irq_id, outirr <= one-hot(irq_id), go to SERVICE.
REQ-030 Withdraw condition and irq_ack in same cycle: ack wins.
REQ-031 SERVICE: irq_req=0, irq_id and irq_dest held; no nesting, new pendings only latch.
REQ-032 SERVICE with irq_iret: outirr <= 0, go to IDLE; next request may be raised the following cycle.
REQ-033 irq_ack outside REQ and irq_iret outside SERVICE are ignored.
REQ-034 Latency: enabled edge at inirr cycle N -> pending N+1 -> irq_req N+2.

Reset
REQ-035 On rst: state IDLE, ENABLE 0, pending 0, edge history 0, VBASE = VEC_BASE, irq_ret 0, irq_id 0, outirr 0, irq_req 0.
REQ-036 rst mid-REQ or mid-SERVICE aborts immediately; rst overrides all same-cycle inputs.

Structure
REQ-037 State encoding and the four cfg_addr register offsets live in the shared core package.
REQ-038 One sub-module, irq_prio_enc: combinational NCH-bit lowest-index priority encoder with valid flag.

Verification
REQ-039 Enable=0x5, pulse inirr[2] -> irq_req at +2 cycles, irq_id=2, irq_dest=0x108.
REQ-040 inirr[1] and inirr[3] rise together, enable=0xA -> id 1 first; after ack/iret, id 3 requested.
REQ-041 In REQ, ack with pc=0x2000 -> irq_ret=0x2000, outirr=0x2, pending[1]=0; iret -> outirr=0, IDLE.
REQ-042 In REQ id=4, write PENDING 0x10 without ack -> IDLE next cycle, irq_req=0.
REQ-043 Level channel 0 (EDGE_MASK[0]=0) held high through iret -> re-requested; W1C PENDING 0x1 has no effect.
REQ-044 Assert rst in SERVICE -> next cycle all outputs at reset values, VBASE reads 0x100.
